// File: rtl/gold_nic.sv
// Processor-side network interface for the gold ring router: one-entry
// inject/eject buffers, polarity-matched injection, and a small register map.
module gold_nic #(
    parameter int unsigned VC_BIT = 63,
    parameter int unsigned CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    input  logic        net_polarity,
    output logic        net_so,
    input  logic        net_ro,
    output logic [63:0] net_do,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [63:0] net_di
);

    localparam int unsigned DATA_W = 64;
    localparam logic [2:0] A_IN_BUF  = 3'd0;
    localparam logic [2:0] A_IN_STAT = 3'd1;
    localparam logic [2:0] A_OUT_BUF = 3'd2;
    localparam logic [2:0] A_OUT_ST  = 3'd3;
    localparam logic [2:0] A_TX_CNT  = 3'd4;
    localparam logic [2:0] A_RX_CNT  = 3'd5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] r_out_buf;
    logic              r_out_full;
    logic [DATA_W-1:0] r_in_buf;
    logic              r_in_full;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [DATA_W-1:0] r_d_out;

    logic              w_wr;
    logic              w_rd;
    logic              w_tx;
    logic              w_rx;
    logic              w_drop;
    logic [DATA_W-1:0] w_rd_data;

    assign w_wr   = nicEn & nicWrEn;
    assign w_rd   = nicEn & ~nicWrEn;
    assign net_so = r_out_full & (r_out_buf[VC_BIT] == net_polarity);
    assign net_ri = ~r_in_full;
    assign net_do = r_out_buf;
    assign d_out  = r_d_out;
    assign w_tx   = net_so & net_ro;
    assign w_rx   = net_si & ~r_in_full;
    assign w_drop = net_si & r_in_full;

    // Inject buffer: a write is only accepted into an empty slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
        end else if (w_tx) begin
            r_out_full <= 1'b0;
        end else if (w_wr && (addr == A_OUT_BUF) && !r_out_full) begin
            r_out_buf  <= d_in;
            r_out_full <= 1'b1;
        end
    end

    // Eject buffer: an arrival into an empty slot outranks a same-edge drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_buf  <= '0;
            r_in_full <= 1'b0;
        end else if (w_rx) begin
            r_in_buf  <= net_di;
            r_in_full <= 1'b1;
        end else if (w_rd && (addr == A_IN_BUF)) begin
            r_in_full <= 1'b0;
        end
    end

    // Sticky overflow; a new drop wins over the clear-on-read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_rd && (addr == A_IN_STAT)) begin
            r_overflow <= 1'b0;
        end
    end

    // Saturating traffic counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx && (r_tx_cnt != CNT_MAX)) begin
                r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            end
            if (w_rx && (r_rx_cnt != CNT_MAX)) begin
                r_rx_cnt <= r_rx_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (addr)
            A_IN_BUF:  w_rd_data = r_in_buf;
            A_IN_STAT: w_rd_data = DATA_W'({r_overflow, r_in_full});
            A_OUT_ST:  w_rd_data = DATA_W'(r_out_full);
            A_TX_CNT:  w_rd_data = DATA_W'(r_tx_cnt);
            A_RX_CNT:  w_rd_data = DATA_W'(r_rx_cnt);
            default:   w_rd_data = '0;
        endcase
    end

    // Read data is captured on the read edge and held until the next read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_out <= '0;
        end else if (w_rd) begin
            r_d_out <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_gold_nic.sv
// Bench for gold_nic: reads are scored by a monitor against a queue of
// hand-computed expectations; network-side pins are checked directly.
module tb_gold_nic;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  addr = '0;
    logic [63:0] d_in = '0;
    logic        nicEn = 1'b0;
    logic        nicWrEn = 1'b0;
    logic        net_polarity = 1'b0;
    logic        net_ro = 1'b0;
    logic        net_si = 1'b0;
    logic [63:0] net_di = '0;
    logic [63:0] d_out;
    logic        net_so;
    logic [63:0] net_do;
    logic        net_ri;
    logic [63:0] s_d_out;
    logic        s_net_so;
    logic [63:0] s_net_do;
    logic        s_net_ri;

    int n_checks = 0;
    int n_errors = 0;
    bit pol_run  = 1'b1;

    typedef struct {
        string       nm;
        logic [63:0] exp;
        bit          has_s;
        logic [63:0] exp_s;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    gold_nic dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_polarity(net_polarity),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
    );

    // Narrow-counter copy sharing all inputs, so saturation is reachable quickly
    gold_nic #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(s_d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_polarity(net_polarity),
        .net_so(s_net_so), .net_ro(net_ro), .net_do(s_net_do),
        .net_si(net_si), .net_ri(s_net_ri), .net_di(net_di)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clock; inputs change and are sampled 3 time units after the edge
    task automatic cyc();
        @(posedge clk);
        #2;
        if (pol_run) net_polarity = ~net_polarity;
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [63:0] d);
        addr = a; d_in = d; nicEn = 1'b1; nicWrEn = 1'b1;
        cyc();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input string nm, input logic [63:0] e,
                      input bit hs = 1'b0, input logic [63:0] es = '0);
        rd_exp_t x;
        x.nm = nm; x.exp = e; x.has_s = hs; x.exp_s = es;
        sb_q.push_back(x);
        addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
        cyc();
        nicEn = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] p);
        wr(3'd2, p);
        cyc();
        cyc();
    endtask

    // Monitor: every read edge produces one d_out value to score
    initial begin : monitor
        rd_exp_t x;
        forever begin
            @(posedge clk);
            if (nicEn && !nicWrEn && !reset) begin
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_read actual=%h required=none", d_out);
                end else begin
                    x = sb_q.pop_front();
                    chk(x.nm, d_out, x.exp);
                    if (x.has_s) chk({x.nm, "_sat"}, s_d_out, x.exp_s);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  sent_k;
        bit  pol0;
        bit  exp_so;

        cyc();
        cyc();
        chk("rst_net_so", 64'(net_so), 64'd0);
        chk("rst_net_ri", 64'(net_ri), 64'd1);
        chk("rst_net_do", net_do, 64'd0);
        chk("rst_d_out", d_out, 64'd0);
        reset = 1'b0;
        cyc();

        // Even-VC packet with router always ready
        net_ro = 1'b1;
        wr(3'd2, 64'h0000_0000_0000_00A5);
        pol0 = net_polarity;
        sent_k = -1;
        for (int k = 0; k < 4; k++) begin
            exp_so = (sent_k < 0) && (net_polarity == 1'b0);
            chk("t1_so", 64'(net_so), 64'(exp_so));
            chk("t1_do", net_do, 64'h00A5);
            if (exp_so) sent_k = k;
            cyc();
        end
        chk("t1_first_even", 64'(sent_k), pol0 ? 64'd1 : 64'd0);
        rd(3'd3, "t1_out_full", 64'd0);
        rd(3'd4, "t1_tx", 64'd1);

        // Odd-VC packet held off by router, plus a dropped write while full
        net_ro = 1'b0;
        wr(3'd2, 64'h8000_0000_0000_0001);
        for (int k = 0; k < 6; k++) begin
            chk("t2_so_wait", 64'(net_so), 64'(net_polarity == 1'b1));
            chk("t2_do_wait", net_do, 64'h8000_0000_0000_0001);
            if (k == 2) begin
                addr = 3'd2; d_in = 64'hDEAD; nicEn = 1'b1; nicWrEn = 1'b1;
            end
            cyc();
            nicEn = 1'b0; nicWrEn = 1'b0;
        end
        net_ro = 1'b1;
        pol0 = net_polarity;
        sent_k = -1;
        for (int k = 0; k < 4; k++) begin
            exp_so = (sent_k < 0) && (net_polarity == 1'b1);
            chk("t2_so", 64'(net_so), 64'(exp_so));
            if (exp_so) sent_k = k;
            cyc();
        end
        chk("t2_first_odd", 64'(sent_k), pol0 ? 64'd0 : 64'd1);
        chk("t2_do_kept", net_do, 64'h8000_0000_0000_0001);
        rd(3'd3, "t2_out_full", 64'd0);
        rd(3'd4, "t2_tx", 64'd2);

        // Single arrival and drain
        net_si = 1'b1; net_di = 64'h1234;
        cyc();
        net_si = 1'b0;
        chk("t3_ri_full", 64'(net_ri), 64'd0);
        rd(3'd1, "t3_stat", 64'd1);
        chk("t3_ri_still", 64'(net_ri), 64'd0);
        rd(3'd0, "t3_buf", 64'h1234);
        chk("t3_ri_free", 64'(net_ri), 64'd1);
        rd(3'd5, "t3_rx", 64'd1);
        rd(3'd1, "t3_stat2", 64'd0);

        // Back-to-back arrivals: second dropped, overflow sticky until read
        net_si = 1'b1; net_di = 64'h1111;
        cyc();
        net_di = 64'h2222;
        cyc();
        net_si = 1'b0;
        rd(3'd1, "t4_stat_ovf", 64'd3);
        rd(3'd1, "t4_stat_reread", 64'd1);
        rd(3'd0, "t4_buf_first", 64'h1111);
        cyc();
        cyc();
        chk("t4_dout_hold", d_out, 64'h1111);
        rd(3'd0, "t4_buf_stale", 64'h1111);
        rd(3'd1, "t4_stat_clr", 64'd0);
        rd(3'd5, "t4_rx", 64'd2);
        rd(3'd6, "t4_addr6", 64'd0);
        rd(3'd7, "t4_addr7", 64'd0);
        wr(3'd0, 64'hFFFF);
        wr(3'd3, 64'hFFFF);
        rd(3'd3, "t4_wr_ignored", 64'd0);
        rd(3'd0, "t4_buf_unchanged", 64'h1111);

        // Arrival coincident with a read of an empty buffer
        net_si = 1'b1; net_di = 64'h3333;
        rd(3'd0, "t4_rd_arrival", 64'h1111);
        net_si = 1'b0;
        rd(3'd1, "t4_stat_arr", 64'd1);
        rd(3'd0, "t4_buf_arr", 64'h3333);
        rd(3'd5, "t4_rx3", 64'd3);

        // Counter saturation (narrow copy saturates at 15)
        for (int k = 0; k < 11; k++) send_pkt(64'(k));
        rd(3'd4, "t5_tx13", 64'd13, 1'b1, 64'd13);
        for (int k = 0; k < 3; k++) send_pkt(64'(k + 100));
        rd(3'd4, "t5_tx16", 64'd16, 1'b1, 64'd15);
        for (int k = 0; k < 2; k++) send_pkt(64'(k + 200));
        rd(3'd4, "t5_tx18", 64'd18, 1'b1, 64'd15);

        // Reset with both buffers full
        pol_run = 1'b0;
        net_polarity = 1'b1;
        net_ro = 1'b0;
        wr(3'd2, 64'h8000_0000_0000_00C3);
        net_si = 1'b1; net_di = 64'h55;
        cyc();
        net_si = 1'b0;
        chk("t6_pre_so", 64'(net_so), 64'd1);
        chk("t6_pre_ri", 64'(net_ri), 64'd0);
        chk("t6_pre_do", net_do, 64'h8000_0000_0000_00C3);
        reset = 1'b1;
        #1;
        chk("t6_rst_so", 64'(net_so), 64'd0);
        chk("t6_rst_ri", 64'(net_ri), 64'd1);
        chk("t6_rst_do", net_do, 64'd0);
        chk("t6_rst_dout", d_out, 64'd0);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        rd(3'd1, "t6_in_stat", 64'd0);
        rd(3'd3, "t6_out_stat", 64'd0);
        rd(3'd4, "t6_tx", 64'd0);
        rd(3'd5, "t6_rx", 64'd0);
        rd(3'd0, "t6_in_buf", 64'd0);

        cyc();
        cyc();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gold_nic.md
# gold_nic

Processor-side network interface for the gold ring router. It is the peer that drives the router's PE input channel (`pedi`/`pesi`/`peri`) and drains its PE output channel (`pedo`/`peso`/`pero`). Each direction has a one-entry buffer, and the injection timing is matched to the router's even/odd virtual-channel polarity. The processor sees a small addressed register interface with status flags and traffic counters.

## Interface
- `VC_BIT`, default 63: packet bit that selects the virtual channel (0 = even, 1 = odd).
- `CNT_W`, default 16: width of the tx/rx packet counters.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `addr`, in, 3: processor register address.
- `d_in`, in, 64: processor write data.
- `d_out`, out, 64: processor read data (registered).
- `nicEn`, in, 1: processor access strobe.
- `nicWrEn`, in, 1: 1 = write, 0 = read; qualified by `nicEn`.
- `net_polarity`, in, 1: router polarity (0 = even cycle, 1 = odd cycle).
- `net_so`, out, 1: send to router (drives router `pesi`).
- `net_ro`, in, 1: router ready (from router `peri`).
- `net_do`, out, 64: packet to router (drives router `pedi`).
- `net_si`, in, 1: send from router (router `peso`).
- `net_ri`, out, 1: ready to router (drives router `pero`).
- `net_di`, in, 64: packet from router (router `pedo`).

## Operation
- Register map:
  - 0 = input buffer (read)
  - 1 = input status (read; bit0 `in_full`, bit1 `overflow`)
  - 2 = output buffer (write)
  - 3 = output status (read; bit0 `out_full`)
  - 4 = `tx_count` (read)
  - 5 = `rx_count` (read)
  - 6 and 7 read 0.
- Writes to any address other than 2 are ignored.
- Read data for status and counters is zero-extended to 64 bits.
- Output path:
  - A write to address 2 with `out_full`=0 loads `out_buf` and sets `out_full`.
  - A write with `out_full`=1 is dropped, and `out_buf` is unchanged.
  - `net_do` = `out_buf`, always.
  - `net_so` = `out_full` & (`out_buf[VC_BIT]` == `net_polarity`). It is combinational and never asserted for a packet whose VC does not match the current polarity.
  - A transfer occurs at a posedge where `net_so` & `net_ro`. That edge clears `out_full` and increments `tx_count`.
- Input path:
  - `net_ri` = ~`in_full`, combinational.
  - At a posedge with `net_si` & `net_ri`: `in_buf` <= `net_di`, `in_full` <= 1, and `rx_count` increments.
  - `net_si` while `in_full`=1 drops the packet and sets sticky `overflow`.
- Processor reads:
  - Read of address 0: `d_out` <= `in_buf` and `in_full` clears. If `in_full` is already 0, the stale `in_buf` is returned with no state change.
  - Read of address 1 returns the flags, then clears `overflow`. If `overflow` is being set at the same edge, set wins.
- Counters saturate at all-ones and never wrap.
- Simultaneous events:
  - A processor write to address 2 at the same edge as a network transfer of the old packet is dropped, because `out_full` is sampled before the edge.
  - A read of address 0 at the same edge as an arrival cannot occur, because `net_ri`=0 while full. With `in_full`=0 the arrival is taken and the read returns the stale data.

## Timing
- Reset values: `d_out`=0, `out_buf`=0, `in_buf`=0, `out_full`=0, `in_full`=0, `overflow`=0, counters=0.
- Output reset values follow: `net_so`=0, `net_ri`=1, `net_do`=0.
- Reset asserted mid-transfer discards both buffers immediately; no partial handshake survives.
- Write latency:
  - A write at edge N makes `out_full`=1 after N.
  - `net_so` can rise in cycle N+1 if polarity matches, otherwise in cycle N+2 (polarity toggles every cycle).
- The minimum injection interval is 2 cycles per packet: load, then send.
- Read latency: `d_out` is valid 1 cycle after the `nicEn` read edge, and holds until the next read.
- An arrival at edge N is readable at address 0 by a read issued in cycle N+1 or later. `net_ri` returns to 1 one cycle after the draining read edge.

## Test plan
- Reset, then write 0x0000_0000_0000_00A5 (`VC_BIT`=0) to address 2 while `net_polarity` toggles and `net_ro`=1. Required: `net_so` is high only in even-polarity cycles, the transfer occurs on the first even cycle, `out_full` clears, and `tx_count`=1.
- Odd packet 0x8000_0000_0000_0001 with `net_ro`=0 for 6 cycles, then 1. Required: `net_so` pulses on odd cycles with no transfer; the transfer happens on the first odd cycle with `net_ro`=1; a second write while full is dropped and `net_do` is unchanged.
- `net_si`=1 with `net_di`=0x1234. Required: `net_ri`=0 next cycle, address 1 reads 1, address 0 read returns 0x1234, `net_ri`=1 afterwards, and `rx_count`=1.
- Two back-to-back arrivals with no drain. Required: the second is dropped, address 1 reads 3 and then 1 on re-read, and `in_buf` keeps the first packet.
- Preload `tx_count` to near all-ones by forced traffic, then send 3 more packets. Required: the counter saturates at 0xFFFF.
- Assert `reset` while `out_full`=1 and `in_full`=1. Required: `net_so`=0 and `net_ri`=1 immediately, and every status register reads 0.
